ganesha_scan_ctrl: RTL and testbench
====================================

# ganesha_scan_ctrl

Raster-scan controller for the 32-row × 64-bit Ganesha bitmap ROM. On a start request it walks ROM addresses 0..31 and drives the ROM's `en`/`address` inputs. It absorbs the ROM's one-cycle read latency, then serialises each 64-bit row into a 1-bit pixel stream with a valid/ready handshake. Its downstream consumer is a display or UART formatter. It sits between the top-level control logic and the ROM, and is the only driver of the ROM's `en` and `address`.

## Interface
- `ROWS`, 32: rows per frame; equals ROM depth.
- `COLS`, 64: pixels per row; equals ROM word width.
- `ADDR_W`, 5: ROM address width; `2**ADDR_W >= ROWS`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle frame request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE from any state.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last pixel of the frame is accepted.
- `rom_en`  out  1  ROM read enable.
- `rom_addr`  out  ADDR_W  ROM row address.
- `rom_data`  in  COLS  ROM read data; valid the cycle after `rom_en` is sampled.
- `pix_valid`  out  1  pixel available.
- `pix_ready`  in  1  consumer accepts a pixel.
- `pix_data`  out  1  current pixel value.
- `pix_x`  out  6  current column, 0..COLS-1.
- `pix_y`  out  ADDR_W  current row, 0..ROWS-1.
- `line_end`  out  1  high with `pix_valid` when `pix_x == COLS-1`.
- `frame_end`  out  1  high with `pix_valid` on the last pixel of the frame.

## Operation
- FSM states: IDLE, FETCH, WAIT, SHIFT, DONE.
- IDLE:
  - `start=1` → FETCH with row counter = 0.
  - `start` in any other state is ignored.
- FETCH (one cycle): `rom_en=1`, `rom_addr=row` → WAIT.
- WAIT (one cycle): `rom_data` is loaded into a COLS-bit line register, column counter = 0 → SHIFT.
- SHIFT:
  - `pix_valid=1`.
  - `pix_data` = line bit `COLS-1-col` (MSB first).
  - A transfer occurs on a cycle with `pix_valid && pix_ready`; the column then increments.
  - Transfer at col = COLS-1 with row < ROWS-1 → row+1, go to FETCH.
  - Transfer at col = COLS-1 with row = ROWS-1 → DONE.
- DONE (one cycle): `done=1` → IDLE.
- `abort=1` in any state → IDLE next cycle.
  - Counters clear, no `done` pulse, line register contents are don't-care.
  - `abort` takes priority over `start` and over a simultaneous transfer.
- Handshake rule: while `pix_valid && !pix_ready`, `pix_data`, `pix_x`, `pix_y`, `line_end` and `frame_end` hold stable. `pix_valid` never drops until a transfer occurs.
- `rom_en` is 0 outside FETCH. `rom_addr` always equals the row register, so it holds its value between fetches.
- Counters:
  - Row counter wraps only via the return to IDLE; it never exceeds ROWS-1.
  - Column counter is 6 bits and never exceeds COLS-1.

## Timing
- Reset values: state IDLE; `busy`, `done`, `rom_en`, `pix_valid`, `pix_data`, `line_end`, `frame_end` = 0; `rom_addr`, `pix_x`, `pix_y` = 0.
- All outputs are registered or decoded from registered state only; there are no combinational paths from `pix_ready` or `start` to outputs.
- `start` sampled at edge 0: FETCH in cycle 1, WAIT in cycle 2, first `pix_valid` in cycle 3.
- Row overhead is 2 cycles (FETCH + WAIT). With `pix_ready` held at 1, each row takes 66 cycles.
- Full frame with `pix_ready=1`: last pixel transfers in cycle 2112, `done` pulses in cycle 2113, IDLE from cycle 2114.
- A reset asserted mid-frame forces reset values immediately (asynchronously). The first `start` is accepted on the first edge after `rst` deasserts.

## Configuration
- `GANESHA_SCAN_MIRROR_EN` defined:
  - `pix_data` = line bit `col` (LSB first), so the image is mirrored horizontally.
  - `pix_x` still counts 0..COLS-1; all timing is unchanged.
- Not defined: MSB-first order as described in Operation.

## Test plan
- Reset then idle: `rst` pulse → all outputs 0. `start` held 0 for 20 cycles → `rom_en` stays 0 and `busy` stays 0.
- Full frame, `pix_ready=1`, ROM model with row r = `{r, 59'h0}`:
  - `rom_addr` steps 0..31.
  - Pixel 0 of row r equals bit 4 of r.
  - `done` pulses exactly at cycle 2113, exactly once.
- Backpressure: `pix_ready` toggling 1-of-3 during row 5 → outputs stable while stalled, no pixel lost or duplicated, row 5 takes 192 SHIFT cycles.
- Abort at row 10, col 30 → IDLE next cycle, no `done`. A new `start` then fetches `rom_addr=0`.
- Simultaneous `abort` with the final transfer (row 31, col 63) → no `done`, IDLE. `start` while `busy` → ignored, with no frame restart.
- Mirror build: with `GANESHA_SCAN_MIRROR_EN` defined and row 0 = `64'h1` → `pix_data=1` only at x=0.

Source files
------------

// File: rtl/ganesha_scan_ctrl.sv
// ganesha_scan_ctrl
// Raster-scan controller for the 32-row x 64-bit Ganesha bitmap ROM.
// Fetches rows 0..ROWS-1, absorbs the ROM's one-cycle read latency and
// serialises each row into a 1-bit pixel stream with a valid/ready handshake.
// Optional build macro: GANESHA_SCAN_MIRROR_EN selects LSB-first pixel order
// (horizontal mirror); without it pixels leave MSB first.
// Every output is a flop loaded from the next-state decode, so nothing on the
// output side depends combinationally on start, abort or pix_ready.
module ganesha_scan_ctrl #(
  parameter int ROWS   = 32,
  parameter int COLS   = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COLS-1:0]   rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic [5:0]        pix_x,
  output logic [ADDR_W-1:0] pix_y,
  output logic              line_end,
  output logic              frame_end
);

  localparam logic [5:0]        LAST_COL = 6'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ROW_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   row_q;
  logic [ADDR_W-1:0]   row_d;
  logic [5:0]          col_q;
  logic [5:0]          col_d;
  logic [COLS-1:0]     line_q;
  logic [COLS-1:0]     line_d;

  logic                xfer;
  logic                last_col;
  logic                last_row;

  logic                busy_d;
  logic                done_d;
  logic                rom_en_d;
  logic                pix_valid_d;
  logic                pix_data_d;
  logic                line_end_d;
  logic                frame_end_d;

  // Select the pixel of a line for a given column in the configured order.
  function automatic logic pick_pixel(input logic [COLS-1:0] line, input logic [5:0] col);
    logic [5:0] idx;
`ifdef GANESHA_SCAN_MIRROR_EN
    idx = col;
`else
    idx = LAST_COL - col;
`endif
    return line[idx];
  endfunction

  assign xfer     = (state_q == SHIFT) && pix_ready;
  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);

  // Next-state decode; abort wins over start and over a simultaneous transfer.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH: state_d = WAIT;
        WAIT:  state_d = SHIFT;
        SHIFT: begin
          if (xfer && last_col) begin
            if (last_row) begin
              state_d = DONE;
            end else begin
              state_d = FETCH;
            end
          end else begin
            state_d = SHIFT;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the row/column counters and the line register.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    line_d = line_q;
    if (abort) begin
      row_d = ROW_ZERO;
      col_d = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            row_d = ROW_ZERO;
            col_d = 6'd0;
          end else begin
            row_d = row_q;
          end
        end
        WAIT: begin
          // ROM data for the row fetched last cycle is valid now.
          line_d = rom_data;
          col_d  = 6'd0;
        end
        SHIFT: begin
          if (xfer) begin
            if (last_col) begin
              col_d = 6'd0;
              if (last_row) begin
                row_d = row_q;
              end else begin
                row_d = row_q + ROW_ONE;
              end
            end else begin
              col_d = col_q + 6'd1;
            end
          end else begin
            col_d = col_q;
          end
        end
        DONE: begin
          // Row counter wraps back to zero on the return to IDLE.
          row_d = ROW_ZERO;
          col_d = 6'd0;
        end
        default: begin
          row_d = row_q;
          col_d = col_q;
        end
      endcase
    end
  end

  // Output values as they will appear once the next state is registered.
  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    rom_en_d    = (state_d == FETCH);
    pix_valid_d = (state_d == SHIFT);
    if (pix_valid_d) begin
      pix_data_d  = pick_pixel(line_d, col_d);
      line_end_d  = (col_d == LAST_COL);
      frame_end_d = (col_d == LAST_COL) && (row_d == LAST_ROW);
    end else begin
      pix_data_d  = 1'b0;
      line_end_d  = 1'b0;
      frame_end_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Row/column counters and the line register holding the row being shifted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= ROW_ZERO;
      col_q  <= 6'd0;
      line_q <= {COLS{1'b0}};
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      line_q <= line_d;
    end
  end

  // Registered outputs; rom_addr and pix_y track the row counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= ROW_ZERO;
      pix_valid <= 1'b0;
      pix_data  <= 1'b0;
      pix_x     <= 6'd0;
      pix_y     <= ROW_ZERO;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      rom_en    <= rom_en_d;
      rom_addr  <= row_d;
      pix_valid <= pix_valid_d;
      pix_data  <= pix_data_d;
      pix_x     <= col_d;
      pix_y     <= row_d;
      line_end  <= line_end_d;
      frame_end <= frame_end_d;
    end
  end

endmodule

// File: tb/tb_ganesha_scan_ctrl.sv
// Self-checking bench for ganesha_scan_ctrl: directed frames with a queue
// scoreboard of expected pixels and a negedge monitor that pops on transfers.
module tb_ganesha_scan_ctrl;

  localparam int ROWS   = 32;
  localparam int COLS   = 64;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              busy;
  logic              done;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [COLS-1:0]   rom_data = 64'h0;
  logic              pix_valid;
  logic              pix_ready = 1'b1;
  logic              pix_data;
  logic [5:0]        pix_x;
  logic [ADDR_W-1:0] pix_y;
  logic              line_end;
  logic              frame_end;

  always #5 clk = ~clk;

  ganesha_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .line_end(line_end), .frame_end(frame_end)
  );

  // ROM model: row r = {r, 58'h0, (r==0)}, i.e. row 0 = 64'h1, others {r, 59'h0}
  logic [COLS-1:0] rom_mem [ROWS];
  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  typedef struct packed {
    logic       d;
    logic [5:0] x;
    logic [4:0] y;
    logic       le;
    logic       fe;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  int   start_edge = 0;
  int   exp_done_cyc = 0;
  int   exp_last_cyc = 0;
  int   fetch_exp = 0;
  int   done_cnt = 0;
  int   shift5_cnt = 0;
  logic bp_en = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-derived pixel value of row y, column x for the ROM image above.
  function automatic logic exp_pix(input int y, input int x);
`ifdef GANESHA_SCAN_MIRROR_EN
    if (y == 0) return (x == 0);
    if (x >= 59) return ((y >> (x - 59)) & 1) != 0;
    return 1'b0;
`else
    if (x < 5) return ((y >> (4 - x)) & 1) != 0;
    if (y == 0 && x == 63) return 1'b1;
    return 1'b0;
`endif
  endfunction

  task automatic push_frame();
    pix_t p;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        p.d  = exp_pix(y, x);
        p.x  = 6'(x);
        p.y  = 5'(y);
        p.le = (x == COLS - 1);
        p.fe = (x == COLS - 1) && (y == ROWS - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int done_cyc);
    exp_done_cyc = done_cyc;
    exp_last_cyc = done_cyc - 1;
    exp_q.delete();
    push_frame();
    start = 1'b1;
    start_edge = edge_cnt + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (busy && i < budget) begin
      tick();
      i++;
    end
    check({name, "_idle"}, busy, 64'd0);
  endtask

  task automatic wait_pos(input int y, input int x, input int budget);
    int i = 0;
    while (!(pix_valid && pix_y == y && pix_x == x) && i < budget) begin
      tick();
      i++;
    end
    check("reach_pos", (pix_valid && pix_y == y && pix_x == x), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, busy, 64'd0);
    check({name, "_done"}, done, 64'd0);
    check({name, "_rom_en"}, rom_en, 64'd0);
    check({name, "_rom_addr"}, rom_addr, 64'd0);
    check({name, "_pix_valid"}, pix_valid, 64'd0);
    check({name, "_pix_data"}, pix_data, 64'd0);
    check({name, "_pix_x"}, pix_x, 64'd0);
    check({name, "_pix_y"}, pix_y, 64'd0);
    check({name, "_line_end"}, line_end, 64'd0);
    check({name, "_frame_end"}, frame_end, 64'd0);
  endtask

  // Consumer: ready is high except during row 5 of a backpressured frame,
  // where it is high on one SHIFT cycle in three.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en && pix_valid && pix_y == 5) begin
        pix_ready = (ph % 3 == 2);
        ph++;
      end else begin
        pix_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor: scoreboard pops on transfers, stall stability, fetch order, done timing.
  initial begin
    int   cyc;
    logic first_seen = 1'b1;
    logic prev_stall = 1'b0;
    pix_t saved = '0;
    pix_t got;
    pix_t ex;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cyc = edge_cnt - start_edge + 1;
        if (cyc == 1) begin
          fetch_exp  = 0;
          first_seen = 1'b0;
        end
        if (rom_en) begin
          check("rom_addr_step", rom_addr, fetch_exp);
          fetch_exp++;
        end
        if (done) begin
          done_cnt++;
          check("done_cycle", cyc, exp_done_cyc);
        end
        got = {pix_data, pix_x, pix_y, line_end, frame_end};
        if (prev_stall) begin
          check("stall_valid", pix_valid, 64'd1);
          check("stall_hold", got, saved);
        end
        if (pix_valid && !first_seen) begin
          first_seen = 1'b1;
          check("first_valid_cycle", cyc, 64'd3);
        end
        if (pix_valid && pix_ready && !abort) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pixel_extra: got pixel y=%0d x=%0d, expected none", pix_y, pix_x);
          end else begin
            ex = exp_q.pop_front();
            check("pixel", got, ex);
            if (ex.fe) check("last_xfer_cycle", cyc, exp_last_cyc);
          end
        end
        if (pix_valid && pix_y == 5) shift5_cnt++;
        prev_stall = pix_valid && !pix_ready && !abort;
        saved = got;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    int d0;
    int s0;
    for (int r = 0; r < ROWS; r++) begin
      logic [4:0] rv;
      rv = 5'(r);
      rom_mem[r] = {rv, 58'h0, (rv == 5'd0)};
    end

    // Reset, then idle with start low
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (20) begin
      tick();
      check("idle_rom_en", rom_en, 64'd0);
      check("idle_busy", busy, 64'd0);
    end

    // Frame 1: ready held high
    d0 = done_cnt;
    start_frame(2113);
    wait_idle("frame1", 2300);
    check("frame1_done_count", done_cnt - d0, 64'd1);
    check("frame1_fetches", fetch_exp, 64'd32);
    check("frame1_queue_empty", exp_q.size(), 64'd0);

    // Frame 2: 1-of-3 backpressure during row 5
    d0 = done_cnt;
    s0 = shift5_cnt;
    bp_en = 1'b1;
    start_frame(2241);
    wait_idle("frame2", 2500);
    bp_en = 1'b0;
    check("frame2_done_count", done_cnt - d0, 64'd1);
    check("frame2_row5_shift_cycles", shift5_cnt - s0, 64'd192);
    check("frame2_queue_empty", exp_q.size(), 64'd0);

    // Frame 3: abort at row 10, col 30
    d0 = done_cnt;
    start_frame(0);
    wait_pos(10, 30, 1000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 64'd0);
    check("abort_pix_valid", pix_valid, 64'd0);
    check("abort_rom_addr", rom_addr, 64'd0);
    exp_q.delete();
    repeat (5) tick();
    check("abort_no_done", done_cnt - d0, 64'd0);

    // Frame 4: restart fetches row 0, ignored start, abort with final transfer
    d0 = done_cnt;
    start_frame(0);
    check("restart_rom_en", rom_en, 64'd1);
    check("restart_rom_addr", rom_addr, 64'd0);
    wait_pos(3, 10, 400);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", busy, 64'd1);
    wait_pos(31, 63, 2200);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("final_abort_busy", busy, 64'd0);
    check("final_abort_left", exp_q.size(), 64'd1);
    exp_q.delete();
    repeat (5) tick();
    check("final_abort_no_done", done_cnt - d0, 64'd0);

    // Frame 5: asynchronous reset mid-frame, start on first edge after release
    start_frame(0);
    wait_pos(2, 5, 300);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    tick();
    rst = 1'b0;
    start_frame(0);
    check("post_reset_rom_en", rom_en, 64'd1);
    check("post_reset_busy", busy, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("post_reset_abort_busy", busy, 64'd0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
